// File: rtl/xy_move_seq_pkg.sv
// Shared types and constants for the XY move sequencer.
// States, direction codes, register offsets and CMD field layout.
package xy_move_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_CCW  = 2'b01;
    localparam logic [1:0] DIR_CW   = 2'b10;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_REM  = 2'd1;
    localparam logic [1:0] REG_DONE = 2'd2;

    localparam int CMD_SX_LSB = 0;
    localparam int CMD_SY_LSB = 14;
    localparam int CMD_DX_LSB = 28;
    localparam int CMD_DY_LSB = 30;

    // Code 11 is not a legal direction; treat it as no motion.
    function automatic logic [1:0] norm_dir(input logic [1:0] d);
        return (d == 2'b11) ? DIR_NONE : d;
    endfunction

endpackage

// File: rtl/xy_move_sequencer_step_edge_counter.sv
// Per-axis pulse synchroniser, step detector and remaining-step counter.
// A step is a change between two nonzero synced coil patterns.
module step_edge_counter #(
    parameter int STEP_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_pulse,
    input  logic              i_load,
    input  logic [STEP_W-1:0] i_load_val,
    input  logic              i_clear,
    input  logic              i_count_en,
    output logic [3:0]        o_pulse_sync,
    output logic [STEP_W-1:0] o_rem,
    output logic              o_zero
);

    logic [3:0]        r_meta;
    logic [3:0]        r_sync;
    logic [3:0]        r_prev;
    logic [STEP_W-1:0] r_rem;
    logic              w_step;

    assign w_step = (r_sync != r_prev) && (|r_sync) && (|r_prev);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_rem  <= '0;
        end else begin
            r_meta <= i_pulse;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (i_clear) begin
                r_rem <= '0;
            end else if (i_load) begin
                r_rem <= i_load_val;
            end else if (i_count_en && w_step && (r_rem != '0)) begin
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    assign o_pulse_sync = r_sync;
    assign o_rem        = r_rem;
    assign o_zero       = (r_rem == '0);

endmodule

// File: rtl/xy_move_sequencer.sv
// APB3 XY move command queue and two-axis stepper sequencer.
// Optional interrupt output enabled by defining XY_MOVE_SEQ_IRQ_EN.
module xy_move_sequencer
    import xy_move_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int STEP_W        = 14,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [3:0]  pulseX,
    input  logic [3:0]  pulseY,
    output logic [1:0]  dirX,
    output logic [1:0]  dirY,
`ifdef XY_MOVE_SEQ_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    state_t            r_state;
    logic [1:0]        r_dirx_cmd;
    logic [1:0]        r_diry_cmd;
    logic              r_zero_seen;
    logic [SW-1:0]     r_settle_cnt;
    logic [15:0]       r_done;
    logic              r_aborted;
    logic              r_ovf;
    logic              r_irq_pend;

    logic              w_wr;
    logic [1:0]        w_addr;
    logic              w_cmd_wr;
    logic              w_ctrl_wr;
    logic              w_abort;
    logic              w_clr_ovf;
    logic              w_clr_irq;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic [AW:0]       w_count;
    logic [31:0]       w_head;
    logic [3:0]        w_sync_x;
    logic [3:0]        w_sync_y;
    logic [STEP_W-1:0] w_rem_x;
    logic [STEP_W-1:0] w_rem_y;
    logic              w_zero_x;
    logic              w_zero_y;
    logic              w_pulse_idle;
    logic              w_count_en;
    logic              w_settle_done;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_wr      = PSEL & PENABLE & PWRITE;
    assign w_addr    = PADDR[3:2];
    assign w_cmd_wr  = w_wr && (w_addr == REG_CMD);
    assign w_ctrl_wr = w_wr && (w_addr == REG_CTRL);
    assign w_abort   = w_ctrl_wr && PWDATA[0];
    assign w_clr_ovf = w_ctrl_wr && PWDATA[1];
`ifdef XY_MOVE_SEQ_IRQ_EN
    assign w_clr_irq = w_ctrl_wr && PWDATA[2];
`else
    assign w_clr_irq = 1'b0;
`endif
    assign w_unused  = ^{PADDR[31:4], PADDR[1:0]};

    // Pointers carry an extra wrap bit so full and empty are distinct.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_fifo[r_rd_ptr[AW-1:0]];

    assign w_pop     = (r_state == IDLE) && !w_empty && !w_abort;
    assign w_push    = w_cmd_wr && !w_abort && (!w_full || w_pop);
    assign w_ovf_set = w_cmd_wr && !w_abort && w_full && !w_pop;

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= PWDATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN || w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_count_en = (r_state == RUN);

    step_edge_counter #(.STEP_W(STEP_W)) u_cnt_x (
        .i_clk        (PCLK),
        .i_rst_n      (PRESERN),
        .i_pulse      (pulseX),
        .i_load       (w_pop),
        .i_load_val   (w_head[CMD_SX_LSB +: STEP_W]),
        .i_clear      (w_abort),
        .i_count_en   (w_count_en),
        .o_pulse_sync (w_sync_x),
        .o_rem        (w_rem_x),
        .o_zero       (w_zero_x)
    );

    step_edge_counter #(.STEP_W(STEP_W)) u_cnt_y (
        .i_clk        (PCLK),
        .i_rst_n      (PRESERN),
        .i_pulse      (pulseY),
        .i_load       (w_pop),
        .i_load_val   (w_head[CMD_SY_LSB +: STEP_W]),
        .i_clear      (w_abort),
        .i_count_en   (w_count_en),
        .o_pulse_sync (w_sync_y),
        .o_rem        (w_rem_y),
        .o_zero       (w_zero_y)
    );

    assign w_pulse_idle  = (w_sync_x == 4'b0000) && (w_sync_y == 4'b0000);
    assign w_settle_done = (r_settle_cnt == SW'(SETTLE_CYCLES - 1));

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_state      <= IDLE;
            r_dirx_cmd   <= DIR_NONE;
            r_diry_cmd   <= DIR_NONE;
            r_zero_seen  <= 1'b0;
            r_settle_cnt <= '0;
            r_done       <= '0;
            r_aborted    <= 1'b0;
            r_ovf        <= 1'b0;
            r_irq_pend   <= 1'b0;
        end else begin
            if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_clr_irq) begin
                r_irq_pend <= 1'b0;
            end
            if (w_abort) begin
                r_state     <= STOPPING;
                r_zero_seen <= 1'b0;
                r_aborted   <= 1'b1;
                r_dirx_cmd  <= DIR_NONE;
                r_diry_cmd  <= DIR_NONE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_pop) begin
                            r_state    <= RUN;
                            r_aborted  <= 1'b0;
                            r_dirx_cmd <= norm_dir(w_head[CMD_DX_LSB +: 2]);
                            r_diry_cmd <= norm_dir(w_head[CMD_DY_LSB +: 2]);
                        end
                    end
                    RUN: begin
                        if (w_zero_x && w_zero_y) begin
                            r_state     <= STOPPING;
                            r_zero_seen <= 1'b0;
                        end
                    end
                    STOPPING: begin
                        // Two consecutive idle samples mean both drivers stopped.
                        if (w_pulse_idle) begin
                            if (r_zero_seen) begin
                                r_state      <= SETTLE;
                                r_settle_cnt <= '0;
                            end else begin
                                r_zero_seen <= 1'b1;
                            end
                        end else begin
                            r_zero_seen <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (w_settle_done) begin
                            r_state <= IDLE;
                            if (!r_aborted) begin
                                r_done <= r_done + 16'd1;
                            end
`ifdef XY_MOVE_SEQ_IRQ_EN
                            if (w_empty) begin
                                r_irq_pend <= 1'b1;
                            end
`endif
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Direction drops in the same cycle the axis counter reaches zero.
    assign dirX = ((r_state == RUN) && !w_zero_x) ? r_dirx_cmd : DIR_NONE;
    assign dirY = ((r_state == RUN) && !w_zero_y) ? r_diry_cmd : DIR_NONE;
    assign busy = (r_state != IDLE) || !w_empty;

`ifdef XY_MOVE_SEQ_IRQ_EN
    assign irq = r_irq_pend;
`endif

    always_comb begin
        w_status       = '0;
        w_status[1:0]  = r_state;
        w_status[6:2]  = 5'(w_count);
        w_status[7]    = r_ovf;
        w_status[8]    = busy;
        w_status[9]    = r_irq_pend;
    end

    always_comb begin
        PRDATA = '0;
        unique case (w_addr)
            REG_CMD:  PRDATA = w_status;
            REG_REM:  PRDATA = 32'(w_rem_x) | (32'(w_rem_y) << 16);
            REG_DONE: PRDATA = {16'h0000, r_done};
            default:  PRDATA = '0;
        endcase
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0 & w_unused;

endmodule

// File: tb/tb_xy_move_sequencer.sv
// Directed scoreboard bench for xy_move_sequencer.
// Expectations are queued when stimulus is driven and popped at each check.
module tb_xy_move_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESERN;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  pulseX;
    logic [3:0]  pulseY;
    logic [1:0]  dirX;
    logic [1:0]  dirY;
    logic        busy;
`ifdef XY_MOVE_SEQ_IRQ_EN
    logic        irq;
`endif

    localparam logic [1:0] CW   = 2'b10;
    localparam logic [1:0] CCW  = 2'b01;
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int px_i = 0;
    int py_i = 0;

    xy_move_sequencer #(
        .FIFO_DEPTH    (4),
        .STEP_W        (14),
        .SETTLE_CYCLES (32)
    ) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .pulseX  (pulseX),
        .pulseY  (pulseY),
        .dirX    (dirX),
        .dirY    (dirY),
`ifdef XY_MOVE_SEQ_IRQ_EN
        .irq     (irq),
`endif
        .busy    (busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] phase(input int i);
        case (i)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] mk_cmd(input int sx, input int sy,
                                           input logic [1:0] dx,
                                           input logic [1:0] dy);
        logic [13:0] x;
        logic [13:0] y;
        x = 14'(sx);
        y = 14'(sy);
        return {dy, dx, y, x};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1;
        PWRITE = 1'b1;
        PENABLE = 1'b0;
        PADDR = a;
        PWDATA = d;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        PADDR = a;
        #1;
        d = PRDATA;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim,
                              input string tag);
        logic [31:0] v;
        int k;
        k = 0;
        expect_val({30'd0, s});
        rd(32'h0, v);
        while (v[1:0] != s && k < lim) begin
            tick(1);
            rd(32'h0, v);
            k++;
        end
        check(tag, {30'd0, v[1:0]});
    endtask

    task automatic step_x();
        px_i = (px_i + 1) % 4;
        pulseX = phase(px_i);
        tick(2);
    endtask

    task automatic step_y();
        py_i = (py_i + 1) % 4;
        pulseY = phase(py_i);
        tick(2);
    endtask

    task automatic start_x();
        px_i = 0;
        pulseX = phase(0);
        tick(2);
    endtask

    task automatic start_y();
        py_i = 0;
        pulseY = phase(0);
        tick(2);
    endtask

    logic [31:0] v;
    logic [3:0]  seen;
    logic        dir_nz;

    initial begin
        PRESERN = 1'b0;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = '0;
        PWDATA = '0;
        pulseX = '0;
        pulseY = '0;
        tick(3);
        PRESERN = 1'b1;
        tick(1);

        // reset state
        expect_val(32'h0); rd(32'h0, v); check("rst_status", v);
        expect_val(32'h0); rd(32'h4, v); check("rst_rem", v);
        expect_val(32'h0); rd(32'h8, v); check("rst_done", v);
        expect_val(32'h0); rd(32'hC, v); check("rst_reg3", v);
        expect_val(32'h0); check("rst_dirs", {27'd0, busy, dirY, dirX});
        expect_val(32'h2); check("rst_apb", {30'd0, PREADY, PSLVERR});

        // X=5 CW, Y=0
        apb_write(32'h0, mk_cmd(5, 0, CW, NONE));
        wait_state(S_RUN, 10, "t1_run");
        expect_val(32'h2); check("t1_dirs_run", {28'd0, dirY, dirX});
        start_x();
        repeat (4) step_x();
        expect_val(32'h2);
        expect_val(32'h1);
        tick(3);
        check("t1_dirs_4", {28'd0, dirY, dirX});
        rd(32'h4, v); check("t1_rem_4", v);
        step_x();
        expect_val(32'h0);
        expect_val(32'h0);
        tick(3);
        check("t1_dirs_5", {28'd0, dirY, dirX});
        rd(32'h4, v); check("t1_rem_5", v);
        wait_state(S_STOP, 2, "t1_stop");
        pulseX = 4'b0000;
        wait_state(S_IDLE, 200, "t1_idle");
        expect_val(32'h1); rd(32'h8, v); check("t1_done", v);
`ifdef XY_MOVE_SEQ_IRQ_EN
        expect_val(32'h1); check("t1_irq", {31'd0, irq});
        apb_write(32'h4, 32'h4);
        expect_val(32'h0); check("t1_irq_clr", {31'd0, irq});
`endif

        // X=3 CW, Y=7 CCW
        apb_write(32'h0, mk_cmd(3, 7, CW, CCW));
        wait_state(S_RUN, 10, "t3_run");
        expect_val(32'h6); check("t3_dirs_run", {28'd0, dirY, dirX});
        start_x();
        start_y();
        repeat (3) begin
            step_x();
            step_y();
        end
        expect_val(32'h4);
        expect_val(32'h0004_0000);
        tick(3);
        check("t3_dirs_x0", {28'd0, dirY, dirX});
        rd(32'h4, v); check("t3_rem_x0", v);
        repeat (4) step_y();
        expect_val(32'h0);
        expect_val(32'h0);
        tick(3);
        check("t3_dirs_end", {28'd0, dirY, dirX});
        rd(32'h4, v); check("t3_rem_end", v);
        wait_state(S_STOP, 2, "t3_stop");
        step_x();
        step_x();
        step_y();
        expect_val(32'h0);
        tick(3);
        rd(32'h4, v); check("t3_rem_overshoot", v);
        pulseX = 4'b0000;
        pulseY = 4'b0000;
        wait_state(S_IDLE, 200, "t3_idle");
        expect_val(32'h2); rd(32'h8, v); check("t3_done", v);
        apb_write(32'h4, 32'h4);

        // both counts zero
        seen = '0;
        dir_nz = 1'b0;
        apb_write(32'h0, mk_cmd(0, 0, CW, CW));
        expect_val(32'hF);
        expect_val(32'h0);
        expect_val(32'h3);
        for (int k = 0; k < 200; k++) begin
            rd(32'h0, v);
            seen[v[1:0]] = 1'b1;
            if ((dirX | dirY) != 2'b00) dir_nz = 1'b1;
            if (seen[1] && v[1:0] == S_IDLE) break;
            tick(1);
        end
        check("t5_states", {28'd0, seen});
        check("t5_dirs", {31'd0, dir_nz});
        rd(32'h8, v); check("t5_done", v);
        apb_write(32'h4, 32'h4);

        // overflow with FSM held in STOPPING
        apb_write(32'h0, mk_cmd(1, 0, CW, NONE));
        wait_state(S_RUN, 10, "t2_run");
        start_x();
        step_x();
        tick(3);
        wait_state(S_STOP, 2, "t2_stop");
        repeat (5) apb_write(32'h0, mk_cmd(2, 2, CW, CW));
        expect_val(32'h192); rd(32'h0, v); check("t2_ovf", v);
        apb_write(32'h4, 32'h2);
        expect_val(32'h112); rd(32'h0, v); check("t2_ovf_clr", v);
        apb_write(32'h4, 32'h1);
        expect_val(32'h102); rd(32'h0, v); check("t2_abort", v);
        pulseX = 4'b0000;
        wait_state(S_IDLE, 200, "t2_idle");
        expect_val(32'h3); rd(32'h8, v); check("t2_done", v);
        apb_write(32'h4, 32'h4);

        // abort in RUN with 2 queued
        apb_write(32'h0, mk_cmd(10, 0, CW, NONE));
        wait_state(S_RUN, 10, "t4_run");
        apb_write(32'h0, mk_cmd(1, 1, CW, CW));
        apb_write(32'h0, mk_cmd(1, 1, CW, CW));
        expect_val(32'hA); rd(32'h4, v); check("t4_rem", v);
        expect_val(32'h109); rd(32'h0, v); check("t4_status", v);
        apb_write(32'h4, 32'h1);
        expect_val(32'h0); check("t4_dirs", {28'd0, dirY, dirX});
        expect_val(32'h102); rd(32'h0, v); check("t4_status_ab", v);
        expect_val(32'h0); rd(32'h4, v); check("t4_rem_ab", v);
        wait_state(S_IDLE, 200, "t4_idle");
        expect_val(32'h3); rd(32'h8, v); check("t4_done", v);
        expect_val(32'h0); rd(32'h0, v); check("t4_status_end", v & 32'h1FF);

        // reset mid-RUN
        apb_write(32'h0, mk_cmd(5, 0, CW, NONE));
        wait_state(S_RUN, 10, "t6_run");
        expect_val(32'h2); check("t6_dirs_run", {28'd0, dirY, dirX});
        PRESERN = 1'b0;
        tick(1);
        expect_val(32'h0); check("t6_dirs", {28'd0, dirY, dirX});
        expect_val(32'h0); check("t6_busy", {31'd0, busy});
        expect_val(32'h0); rd(32'h0, v); check("t6_status", v);
        expect_val(32'h0); rd(32'h8, v); check("t6_done", v);
`ifdef XY_MOVE_SEQ_IRQ_EN
        expect_val(32'h0); check("t6_irq", {31'd0, irq});
`endif
        PRESERN = 1'b1;
        tick(3);
        expect_val(32'h0); rd(32'h0, v); check("t6_status_after", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
